// File: rtl/reg_write_arbiter.sv
// Round-robin owner arbiter for the single write port of a 32-bit register.
// Each requester owns the port for a whole multi-write transaction. A hold
// timeout (MAX_HOLD granted cycles) forces a long-running owner to give way.
// All state advances only on clock edges qualified by clock_valid, including
// reset, so the arbiter stays in lock-step with the register it drives.
module reg_write_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_HOLD   = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        clock_valid,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ-1:0]            wr,
  input  logic [N_REQ*DATA_WIDTH-1:0] wdata,
  output logic [N_REQ-1:0]            gnt,
  output logic                        reg_write,
  output logic [DATA_WIDTH-1:0]       reg_data,
  output logic [N_REQ-1:0]            revoked,
  output logic                        busy
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  // Counter only needs to reach MAX_HOLD-1; with the timeout disabled a
  // single saturating bit is enough.
  localparam int CNT_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = (MAX_HOLD > 0) ? CNT_W'(MAX_HOLD - 1) : '1;

  typedef enum logic {IDLE, OWNED} state_t;

  state_t           state, state_nxt;
  logic [PTR_W-1:0] ptr, ptr_nxt;
  logic [PTR_W-1:0] owner, owner_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [N_REQ-1:0] gnt_nxt, revoked_nxt;
  logic             found;
  logic [PTR_W-1:0] winner;
  logic [PTR_W-1:0] scan;

  // Requester index after v, wrapping at N_REQ (also for non-power-of-two N_REQ).
  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] v);
    return (v == LAST_IDX) ? '0 : v + 1'b1;
  endfunction

  // Round-robin search: first set req bit starting at ptr and wrapping.
  always_comb begin
    found  = 1'b0;
    winner = ptr;
    scan   = ptr;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req[scan]) begin
        found  = 1'b1;
        winner = scan;
      end
      scan = wrap_inc(scan);
    end
  end

  // Next-state logic: grant, release, timeout and hold counting.
  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    owner_nxt   = owner;
    cnt_nxt     = cnt;
    gnt_nxt     = gnt;
    revoked_nxt = '0;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = OWNED;
          owner_nxt = winner;
          gnt_nxt   = N_REQ'(1) << winner;
          cnt_nxt   = '0;
        end
      end
      OWNED: begin
        if (!req[owner]) begin
          // Voluntary release wins over a timeout landing on the same edge.
          state_nxt = IDLE;
          gnt_nxt   = '0;
          ptr_nxt   = wrap_inc(owner);
        end else if (MAX_HOLD > 0 && cnt == CNT_LAST) begin
          state_nxt   = IDLE;
          gnt_nxt     = '0;
          revoked_nxt = gnt;
          ptr_nxt     = wrap_inc(owner);
        end else if (cnt != '1) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  // State register; clock_valid=0 freezes everything, reset included.
  always_ff @(posedge clock) begin
    if (clock_valid) begin
      if (reset) begin
        state   <= IDLE;
        ptr     <= '0;
        owner   <= '0;
        cnt     <= '0;
        gnt     <= '0;
        revoked <= '0;
      end else begin
        state   <= state_nxt;
        ptr     <= ptr_nxt;
        owner   <= owner_nxt;
        cnt     <= cnt_nxt;
        gnt     <= gnt_nxt;
        revoked <= revoked_nxt;
      end
    end
  end

  // Write-port mux: only the current owner's strobe and data reach the register.
  always_comb begin
    reg_write = 1'b0;
    reg_data  = '0;
    if (state == OWNED) begin
      reg_write = gnt[owner] & wr[owner];
      reg_data  = wdata[owner*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign busy = (state == OWNED);

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
Round-robin arbiter that shares the single write port of a 32-bit `register` instance among N_REQ requesters. Each requester holds ownership for a multi-write transaction; the block muxes the owner's data and write strobe onto the register's data_in/write pins. A hold-timeout prevents any requester from monopolising the register. Like the register, it honours the shared clock_valid qualifier.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 32, width of write data
MAX_HOLD, 16, maximum granted cycles per ownership; 0 disables the timeout

Ports:
clock  input  1  system clock
reset  input  1  synchronous active-high reset, sampled only when clock_valid=1
clock_valid  input  1  edge qualifier; 0 freezes all state, including reset
req  input  N_REQ  ownership request, one bit per requester, level held for the whole transaction
wr  input  N_REQ  write strobe per requester
wdata  input  N_REQ*DATA_WIDTH  write data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
gnt  output  N_REQ  registered one-hot grant
reg_write  output  1  to register.write
reg_data  output  DATA_WIDTH  to register.data_in
revoked  output  N_REQ  one-cycle pulse when a grant is removed by timeout
busy  output  1  1 while in OWNED

Behaviour:
- Clock, reset and enable:
  - reset is synchronous, active-high, on clock.
  - Every state update requires a posedge with clock_valid=1. With clock_valid=0 nothing changes; pending reset is ignored, matching `register`.
- Reset values:
  - state=IDLE, gnt=0, revoked=0, busy=0.
  - Priority pointer ptr=0, hold counter cnt=0.
  - reg_write=0, reg_data=0 follow combinationally.
- States: IDLE, OWNED.
- IDLE:
  - No req bits set: stay in IDLE.
  - Any req bit set: at the next valid edge, pick the first set bit searching ptr, ptr+1, ... with wrap mod N_REQ.
  - Then gnt is set one-hot to the winner, state=OWNED, cnt=0.
  - Grant latency is one valid edge after req is sampled.
- OWNED, owner o:
  - reg_write = gnt[o] & wr[o], combinational.
  - reg_data = wdata slice o.
  - wr from non-owners is ignored.
  - Each valid edge in OWNED increments cnt.
- Release:
  - req[o]=0 sampled at a valid edge: gnt=0, state=IDLE, ptr=(o+1) mod N_REQ.
  - A write strobed in that same cycle still occurs, because gnt is still high.
  - IDLE then costs one bubble cycle before the next grant.
- Timeout (MAX_HOLD>0):
  - Trigger: cnt==MAX_HOLD-1 with req[o] still 1 at a valid edge.
  - Then gnt=0, revoked[o]=1 for exactly one cycle, state=IDLE, ptr=(o+1) mod N_REQ.
  - A write in the final granted cycle completes.
  - The owner therefore holds gnt for exactly MAX_HOLD cycles.
  - A revoked requester keeping req high re-competes normally.
  - If req[o] drops on the timeout edge, release takes precedence and revoked stays 0.
- Outputs while not OWNED: reg_write=0, reg_data=0.
- busy equals (state==OWNED).
- Reset mid-ownership (clock_valid=1):
  - Immediate return to reset values: gnt drops and ptr=0.
  - A write strobed in that cycle is not guaranteed; `register` also resets on that edge.
- Width rules:
  - ptr is ceil(log2(N_REQ)) bits and wraps mod N_REQ; for non-power-of-two N_REQ, value N_REQ-1 wraps to 0.
  - cnt is wide enough for MAX_HOLD-1 and saturates when MAX_HOLD=0.

Test Plan:
- Single requester: after reset, req=4'b0010 → gnt=4'b0010 one edge later. wr[1]=1 with wdata slice1=32'hDEADBEEF → reg_write=1, reg_data=32'hDEADBEEF. Drop req → gnt=0, busy=0, ptr=2.
- Fairness: req=4'b1111 held, each requester releases after 2 cycles → grant order 0,1,2,3,0, with one IDLE bubble between grants.
- Timeout, MAX_HOLD=16: requester 2 holds req → gnt[2] high exactly 16 cycles, then revoked=4'b0100 for 1 cycle. With req=4'b0101, requester 0 is granted next.
- Isolation: owner 0, wr=4'b1110 with distinct data → reg_write=0. Then wr=4'b0001 → reg_data equals slice0.
- clock_valid low for 5 cycles mid-ownership, with reset pulsed meanwhile → gnt, cnt and ptr unchanged. Raising clock_valid with reset=1 → all outputs 0, ptr=0.
- Simultaneous release and timeout: req[o] drops on cycle MAX_HOLD → gnt=0 and revoked remains 0.
